cmd_assembler: RTL and testbench

CMD_ASSEMBLER -- requirements
Module: cmd_assembler

---
 rtl/cmd_assembler.sv | 122 ++++++++++++
 tb/tb_cmd_assembler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_assembler.sv
// cmd_assembler: pairs two received UART bytes into a 16-bit command {hi, lo}.
// Define CMD_ASM_TIMEOUT_EN to build the inter-byte timeout counter and tmo pulse.
module cmd_assembler #(
   parameter int unsigned TIMEOUT_CYCLES = 52080
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_rdy,
   input  logic [7:0]  rx_data,
   output logic        clr_rx_rdy,
   input  logic        clr_cmd_rdy,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   output logic        tmo
);

   typedef enum logic {StIdle, StWaitLo} state_e;

   state_e      state_q, state_d;
   logic [7:0]  hi_q, hi_d;
   logic [15:0] cmd_q, cmd_d;
   logic        cmd_rdy_q, cmd_rdy_d;
   logic        ack_pend_q, ack_pend_d;
   logic        byte_avail;
   logic        consume;

   if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65536) begin : g_param_check
      $error("TIMEOUT_CYCLES must lie in 1..65536 for a 16-bit counter");
   end

`ifdef CMD_ASM_TIMEOUT_EN
   localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] cnt_q, cnt_d;
   logic        tmo_q, tmo_d;
`endif

   // A byte stays pending until the receiver drops rx_rdy, so a slow clear
   // cannot make the same byte count twice.
   assign byte_avail = rx_rdy & ~ack_pend_q;

   always_comb begin
      state_d   = state_q;
      hi_d      = hi_q;
      cmd_d     = cmd_q;
      cmd_rdy_d = cmd_rdy_q;
      consume   = 1'b0;
`ifdef CMD_ASM_TIMEOUT_EN
      cnt_d     = 16'h0000;
      tmo_d     = 1'b0;
`endif
      if (clr_cmd_rdy) begin
         cmd_rdy_d = 1'b0;
      end
      case (state_q)
         StIdle: begin
            if (byte_avail) begin
               consume   = 1'b1;
               hi_d      = rx_data;
               cmd_rdy_d = 1'b0;
               state_d   = StWaitLo;
            end
         end
         StWaitLo: begin
            if (byte_avail) begin
               consume   = 1'b1;
               cmd_d     = {hi_q, rx_data};
               cmd_rdy_d = 1'b1;
               state_d   = StIdle;
            end
`ifdef CMD_ASM_TIMEOUT_EN
            else if (cnt_q == TmoLast) begin
               hi_d    = 8'h00;
               tmo_d   = 1'b1;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
`endif
         end
         default: state_d = StIdle;
      endcase
      ack_pend_d = consume | (ack_pend_q & rx_rdy);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         hi_q       <= 8'h00;
         cmd_q      <= 16'h0000;
         cmd_rdy_q  <= 1'b0;
         ack_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         hi_q       <= hi_d;
         cmd_q      <= cmd_d;
         cmd_rdy_q  <= cmd_rdy_d;
         ack_pend_q <= ack_pend_d;
      end
   end

`ifdef CMD_ASM_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 16'h0000;
         tmo_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tmo_q <= tmo_d;
      end
   end

   assign tmo = tmo_q;
`else
   assign tmo = 1'b0;
`endif

   assign clr_rx_rdy = consume & rst_n;
   assign cmd        = cmd_q;
   assign cmd_rdy    = cmd_rdy_q;

endmodule

// File: tb/tb_cmd_assembler.sv
// Self-checking bench for cmd_assembler: vector table plus hand sequences,
// completed commands checked against a scoreboard queue.
module tb_cmd_assembler;

   localparam int unsigned TMO_CYC = 16;
`ifdef CMD_ASM_TIMEOUT_EN
   localparam int GAP_LONG = 10;
   localparam int TMO_EXP  = 1;
`else
   localparam int GAP_LONG = 100;
   localparam int TMO_EXP  = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_rdy = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        clr_cmd_rdy = 1'b0;
   logic        clr_rx_rdy;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        tmo;

   cmd_assembler #(.TIMEOUT_CYCLES(TMO_CYC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_rdy      (rx_rdy),
      .rx_data     (rx_data),
      .clr_rx_rdy  (clr_rx_rdy),
      .clr_cmd_rdy (clr_cmd_rdy),
      .cmd         (cmd),
      .cmd_rdy     (cmd_rdy),
      .tmo         (tmo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  hi;
      logic [7:0]  lo;
      int          gap;
      logic [15:0] want;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   int          ack_cnt = 0;
   int          ack_dbl = 0;
   int          tmo_cnt = 0;
   int          bytes_sent = 0;
   logic        prev_clr = 1'b0;
   logic        prev_rdy = 1'b0;
   logic [15:0] exp_q[$];

   task automatic check16(input string name, input logic [15:0] got, input logic [15:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   always @(posedge clk) begin
      if (clr_rx_rdy) ack_cnt <= ack_cnt + 1;
      if (clr_rx_rdy && prev_clr) ack_dbl <= ack_dbl + 1;
      if (tmo) tmo_cnt <= tmo_cnt + 1;
      prev_clr <= clr_rx_rdy;
   end

   // Scoreboard: every completion is preceded by a high-byte capture that
   // clears cmd_rdy, so each completion shows up as a rising cmd_rdy.
   always @(negedge clk) begin
      if (cmd_rdy && !prev_rdy) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got cmd %h want no completion", cmd);
         end else begin
            check16("sb_cmd", cmd, exp_q.pop_front());
         end
      end
      prev_rdy <= cmd_rdy;
   end

   // Called at a negedge; returns at the second negedge after consumption.
   task automatic send_byte(input logic [7:0] b, input bit push, input logic [15:0] want);
      int n;
      rx_data = b;
      rx_rdy  = 1'b1;
      if (push) exp_q.push_back(want);
      bytes_sent++;
      n = 0;
      #1;
      while (!clr_rx_rdy && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      check16("ack_seen", {15'b0, clr_rx_rdy}, 16'h0001);
      @(posedge clk);
      @(negedge clk);
      rx_rdy = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t        vecs[5];
      logic [15:0] last_cmd;
      int          a0;

      vecs[0] = '{hi: 8'hA5, lo: 8'h3C, gap: GAP_LONG, want: 16'hA53C};
      vecs[1] = '{hi: 8'h00, lo: 8'hFF, gap: 0,        want: 16'h00FF};
      vecs[2] = '{hi: 8'hFF, lo: 8'h00, gap: 3,        want: 16'hFF00};
      // gap 14 puts the low byte exactly on counter == TIMEOUT_CYCLES-1
      vecs[3] = '{hi: 8'h5A, lo: 8'hC3, gap: 14,       want: 16'h5AC3};
      vecs[4] = '{hi: 8'h81, lo: 8'h7E, gap: 1,        want: 16'h817E};

      // Reset state, with rx_rdy high to show no ack while in reset
      rx_rdy = 1'b1;
      repeat (3) @(negedge clk);
      check16("rst_clr_rx", {15'b0, clr_rx_rdy}, 16'h0000);
      check16("rst_cmd", cmd, 16'h0000);
      check16("rst_cmd_rdy", {15'b0, cmd_rdy}, 16'h0000);
      check16("rst_tmo", {15'b0, tmo}, 16'h0000);
      rx_rdy = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      last_cmd = 16'h0000;
      for (int i = 0; i < 5; i++) begin
         a0 = ack_cnt;
         send_byte(vecs[i].hi, 1'b0, 16'h0000);
         check16("hold_on_hi", cmd, last_cmd);
         check16("clear_on_hi", {15'b0, cmd_rdy}, 16'h0000);
         repeat (vecs[i].gap) @(negedge clk);
         send_byte(vecs[i].lo, 1'b1, vecs[i].want);
         check16("vec_cmd", cmd, vecs[i].want);
         check16("vec_cmd_rdy", {15'b0, cmd_rdy}, 16'h0001);
         check16("vec_acks", 16'(ack_cnt - a0), 16'd2);
         last_cmd = vecs[i].want;
      end

      // Receiver slow to clear: rx_rdy held 5 cycles consumes one byte only
      a0 = ack_cnt;
      rx_data = 8'h12;
      rx_rdy  = 1'b1;
      repeat (5) @(negedge clk);
      rx_rdy = 1'b0;
      @(negedge clk);
      check16("hold_acks", 16'(ack_cnt - a0), 16'd1);
      send_byte(8'h34, 1'b1, 16'h1234);
      check16("hold_cmd", cmd, 16'h1234);

`ifdef CMD_ASM_TIMEOUT_EN
      send_byte(8'h11, 1'b0, 16'h0000);
      repeat (14) @(negedge clk);
      check16("tmo_early", {15'b0, tmo}, 16'h0000);
      @(negedge clk);
      check16("tmo_pulse", {15'b0, tmo}, 16'h0001);
      check16("tmo_cmd_kept", cmd, 16'h1234);
      check16("tmo_cmd_rdy_kept", {15'b0, cmd_rdy}, 16'h0000);
      @(negedge clk);
      check16("tmo_one_cycle", {15'b0, tmo}, 16'h0000);
      send_byte(8'h22, 1'b0, 16'h0000);
      repeat (2) @(negedge clk);
      send_byte(8'h33, 1'b1, 16'h2233);
      check16("post_tmo_cmd", cmd, 16'h2233);
`else
      send_byte(8'h11, 1'b0, 16'h0000);
      repeat (30) @(negedge clk);
      check16("no_tmo", {15'b0, tmo}, 16'h0000);
      send_byte(8'h22, 1'b1, 16'h1122);
      check16("late_lo_cmd", cmd, 16'h1122);
`endif

      // Completion coinciding with clr_cmd_rdy: set wins, next clear takes effect
      send_byte(8'hBE, 1'b0, 16'h0000);
      rx_data     = 8'hEF;
      rx_rdy      = 1'b1;
      clr_cmd_rdy = 1'b1;
      bytes_sent++;
      exp_q.push_back(16'hBEEF);
      @(posedge clk);
      @(negedge clk);
      check16("set_wins_rdy", {15'b0, cmd_rdy}, 16'h0001);
      check16("set_wins_cmd", cmd, 16'hBEEF);
      rx_rdy = 1'b0;
      @(negedge clk);
      check16("clr_cmd_rdy", {15'b0, cmd_rdy}, 16'h0000);
      check16("clr_cmd_kept", cmd, 16'hBEEF);
      clr_cmd_rdy = 1'b0;
      @(negedge clk);

      // Asynchronous reset while a high byte is held
      send_byte(8'h7E, 1'b0, 16'h0000);
      #2;
      rst_n   = 1'b0;
      rx_data = 8'h55;
      rx_rdy  = 1'b1;
      #1;
      check16("arst_cmd", cmd, 16'h0000);
      check16("arst_cmd_rdy", {15'b0, cmd_rdy}, 16'h0000);
      check16("arst_tmo", {15'b0, tmo}, 16'h0000);
      check16("arst_clr_rx", {15'b0, clr_rx_rdy}, 16'h0000);
      repeat (2) @(negedge clk);
      rx_rdy = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_byte(8'h01, 1'b0, 16'h0000);
      @(negedge clk);
      send_byte(8'h02, 1'b1, 16'h0102);
      check16("post_rst_cmd", cmd, 16'h0102);
      repeat (20) @(negedge clk);

      check16("sb_drained", 16'(exp_q.size()), 16'd0);
      check16("ack_total", 16'(ack_cnt), 16'(bytes_sent + 1));
      check16("ack_no_double", 16'(ack_dbl), 16'd0);
      check16("tmo_total", 16'(tmo_cnt), 16'(TMO_EXP));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
